// File: rtl/window_fetch_sequencer.sv
// Window fetch sequencer: walks a win_h x win_w window over a byte image stored
// 32 pixels per memory line, fetches lines through a single-entry cache and
// streams pixels in raster order with valid/ready handshakes.
module window_fetch_sequencer #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DIM_W  = 12,
  parameter int unsigned WIN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_start,
  input  logic [DIM_W-1:0]  in_base_row,
  input  logic [DIM_W-1:0]  in_base_col,
  input  logic [DIM_W-1:0]  in_width,
  input  logic [ADDR_W-1:0] in_offset,
  input  logic [WIN_W-1:0]  in_win_h,
  input  logic [WIN_W-1:0]  in_win_w,
  output logic              out_req_valid,
  output logic [ADDR_W-1:0] out_req_addr,
  input  logic              in_req_ready,
  input  logic              in_rd_valid,
  input  logic [DATA_W-1:0] in_rd_data,
  output logic              out_pix_valid,
  output logic [7:0]        out_pix,
  output logic              out_pix_last,
  input  logic              in_pix_ready,
  output logic              out_busy,
  output logic              out_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_REQ, S_WAIT, S_EMIT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DIM_W-1:0]  base_row, base_col, width;
  logic [ADDR_W-1:0] offset, addr_q, cache_addr;
  logic [WIN_W-1:0]  win_h, win_w, r, c;
  logic [4:0]        sel_q;
  logic              cache_vld;
  logic [DATA_W-1:0] cache_line;

  logic [DIM_W-1:0]  row, col;
  logic [23:0]       pix;
  logic [ADDR_W-1:0] addr_c;
  logic              last_pix, cache_hit;

  // Address arithmetic for the current window position (r, c).
  always_comb begin
    row       = base_row + DIM_W'(r);
    col       = base_col + DIM_W'(c);
    pix       = 24'(row) * 24'({1'b0, width} + 1'b1) + 24'(col);
    addr_c    = ADDR_W'(pix[23:5]) + offset;
    cache_hit = cache_vld && (addr_c == cache_addr);
    last_pix  = (r == win_h - 1'b1) && (c == win_w - 1'b1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and output decode.
  always_comb begin
    state_nx      = state;
    out_req_valid = 1'b0;
    out_req_addr  = addr_q;
    out_pix_valid = 1'b0;
    out_pix       = '0;
    out_pix_last  = 1'b0;
    out_busy      = 1'b0;
    out_done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_start)
          state_nx = (in_win_h == '0 || in_win_w == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        out_busy = 1'b1;
        state_nx = cache_hit ? S_EMIT : S_REQ;
      end
      S_REQ: begin
        out_busy      = 1'b1;
        out_req_valid = 1'b1;
        if (in_req_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        out_busy = 1'b1;
        if (in_rd_valid) state_nx = S_EMIT;
      end
      S_EMIT: begin
        out_busy      = 1'b1;
        out_pix_valid = 1'b1;
        out_pix       = cache_line[{sel_q, 3'b000} +: 8];
        out_pix_last  = last_pix;
        if (in_pix_ready) state_nx = last_pix ? S_DONE : S_CALC;
      end
      S_DONE: begin
        out_done = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Config latch, position counters, fetch address and line cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_row   <= '0;
      base_col   <= '0;
      width      <= '0;
      offset     <= '0;
      win_h      <= '0;
      win_w      <= '0;
      r          <= '0;
      c          <= '0;
      addr_q     <= '0;
      sel_q      <= '0;
      cache_vld  <= 1'b0;
      cache_addr <= '0;
      cache_line <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_start) begin
            base_row  <= in_base_row;
            base_col  <= in_base_col;
            width     <= in_width;
            offset    <= in_offset;
            win_h     <= in_win_h;
            win_w     <= in_win_w;
            r         <= '0;
            c         <= '0;
            cache_vld <= 1'b0;
          end
        end
        S_CALC: begin
          addr_q <= addr_c;
          sel_q  <= ~pix[4:0];
        end
        S_WAIT: begin
          if (in_rd_valid) begin
            cache_line <= in_rd_data;
            cache_addr <= addr_q;
            cache_vld  <= 1'b1;
          end
        end
        S_EMIT: begin
          if (in_pix_ready) begin
            if (c == win_w - 1'b1) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_window_fetch_sequencer.sv
// Self-checking bench for window_fetch_sequencer: directed windows plus random
// windows against a queue-based reference of expected requests and pixels.
module tb_window_fetch_sequencer;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DIM_W  = 12;
  localparam int unsigned WIN_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_start = 1'b0;
  logic [DIM_W-1:0]  in_base_row = '0, in_base_col = '0, in_width = '0;
  logic [ADDR_W-1:0] in_offset = '0;
  logic [WIN_W-1:0]  in_win_h = '0, in_win_w = '0;
  logic              out_req_valid;
  logic [ADDR_W-1:0] out_req_addr;
  logic              in_req_ready = 1'b1;
  logic              in_rd_valid = 1'b0;
  logic [DATA_W-1:0] in_rd_data = '0;
  logic              out_pix_valid;
  logic [7:0]        out_pix;
  logic              out_pix_last;
  logic              in_pix_ready = 1'b1;
  logic              out_busy;
  logic              out_done;

  window_fetch_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start),
    .in_base_row(in_base_row), .in_base_col(in_base_col), .in_width(in_width),
    .in_offset(in_offset), .in_win_h(in_win_h), .in_win_w(in_win_w),
    .out_req_valid(out_req_valid), .out_req_addr(out_req_addr), .in_req_ready(in_req_ready),
    .in_rd_valid(in_rd_valid), .in_rd_data(in_rd_data),
    .out_pix_valid(out_pix_valid), .out_pix(out_pix), .out_pix_last(out_pix_last),
    .in_pix_ready(in_pix_ready), .out_busy(out_busy), .out_done(out_done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [7:0]        exp_pix[$];
  logic [ADDR_W-1:0] req_log[$];

  // memory / handshake environment state
  logic              pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  int unsigned       pend_lat = 0;
  logic              mem_rnd = 1'b0, rnd_rdy = 1'b0, spur_en = 1'b0;
  int unsigned       req_hold = 0, pix_hold = 0;
  int unsigned       done_cnt = 0, stall_cnt = 0;

  logic              rq_stall = 1'b0, px_stall = 1'b0, px_last = 1'b0;
  logic [ADDR_W-1:0] rq_addr = '0;
  logic [7:0]        px_val = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory content: each byte is a function of line address and pixel position.
  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a, input int unsigned p);
    int unsigned av;
    av = 32'(a);
    return 8'(av * 5 + p * 37 + (av >> 8));
  endfunction

  // Pixel position 0 is the left-most pixel, stored in the most significant byte.
  function automatic logic [DATA_W-1:0] mk_line(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] l;
    l = '0;
    for (int unsigned p = 0; p < 32; p++) l[8*(31-p) +: 8] = mem_byte(a, p);
    return l;
  endfunction

  // Reference: expected line fetches and pixel stream for one window.
  task automatic build_model(input int unsigned br, input int unsigned bc, input int unsigned w,
                             input int unsigned off, input int unsigned h, input int unsigned ww);
    int unsigned row, col, pix, ad, prev;
    bit have;
    have = 0;
    prev = 0;
    for (int unsigned rr = 0; rr < h; rr++) begin
      for (int unsigned cc = 0; cc < ww; cc++) begin
        row = (br + rr) % 4096;
        col = (bc + cc) % 4096;
        pix = (row * (w + 1) + col) % (1 << 24);
        ad  = ((pix / 32) + off) % (1 << 20);
        if (!have || ad != prev) exp_addr.push_back(ADDR_W'(ad));
        have = 1;
        prev = ad;
        exp_pix.push_back(mem_byte(ADDR_W'(ad), pix % 32));
      end
    end
  endtask

  // Drive ready/read-data shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    in_rd_valid = 1'b0;
    if (!rst_n) pend = 1'b0;
    else if (pend) begin
      if (pend_lat <= 1) begin
        in_rd_valid = 1'b1;
        in_rd_data  = mk_line(pend_addr);
        pend = 1'b0;
      end else pend_lat--;
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      in_rd_valid = 1'b1;
      in_rd_data  = {8{$urandom}};
    end
    if (req_hold > 0) begin in_req_ready = 1'b0; req_hold--; end
    else in_req_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (pix_hold > 0) begin in_pix_ready = 1'b0; pix_hold--; end
    else in_pix_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Observe handshakes mid-cycle; they complete at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      rq_stall = 1'b0;
      px_stall = 1'b0;
      pend     = 1'b0;
    end else begin
      if (rq_stall) begin
        check("req_hold_valid", out_req_valid, 1);
        check("req_hold_addr", out_req_addr, rq_addr);
      end
      if (px_stall) begin
        check("pix_hold_valid", out_pix_valid, 1);
        check("pix_hold_val", out_pix, px_val);
        check("pix_hold_last", out_pix_last, px_last);
      end
      rq_stall = out_req_valid && !in_req_ready;
      rq_addr  = out_req_addr;
      px_stall = out_pix_valid && !in_pix_ready;
      px_val   = out_pix;
      px_last  = out_pix_last;
      if (rq_stall) stall_cnt++;
      if (out_req_valid && in_req_ready) begin
        req_log.push_back(out_req_addr);
        check("one_outstanding", pend, 0);
        check("req_expected", exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) check("req_addr", out_req_addr, exp_addr.pop_front());
        pend      = 1'b1;
        pend_addr = out_req_addr;
        pend_lat  = mem_rnd ? $urandom_range(1, 4) : 1;
      end
      if (out_pix_valid && in_pix_ready) begin
        check("pix_expected", exp_pix.size() != 0, 1);
        if (exp_pix.size() != 0) begin
          check("pix_val", out_pix, exp_pix.pop_front());
          check("pix_last", out_pix_last, exp_pix.size() == 0);
        end
      end
      if (out_done) begin
        done_cnt++;
        check("done_busy", out_busy, 0);
      end
    end
  end

  task automatic run_window(input int unsigned br, input int unsigned bc, input int unsigned w,
                            input int unsigned off, input int unsigned h, input int unsigned ww,
                            input bit poke, output int unsigned cyc);
    int unsigned d0, limit;
    req_log.delete();
    build_model(br, bc, w, off, h, ww);
    d0    = done_cnt;
    limit = 200 + 80 * h * ww;
    @(posedge clk); #2;
    in_base_row = DIM_W'(br);
    in_base_col = DIM_W'(bc);
    in_width    = DIM_W'(w);
    in_offset   = ADDR_W'(off);
    in_win_h    = WIN_W'(h);
    in_win_w    = WIN_W'(ww);
    in_start    = 1'b1;
    @(posedge clk); #2;
    in_start = 1'b0;
    cyc = 1;
    if (poke) begin
      @(posedge clk); #2;
      in_base_row = DIM_W'($urandom);
      in_base_col = DIM_W'($urandom);
      in_width    = DIM_W'($urandom);
      in_offset   = ADDR_W'($urandom);
      in_win_h    = WIN_W'($urandom);
      in_win_w    = WIN_W'($urandom);
      in_start    = 1'b1;
      @(posedge clk); #2;
      in_start = 1'b0;
      cyc += 2;
    end
    while (done_cnt == d0 && cyc < limit) begin
      @(posedge clk);
      cyc++;
    end
    check("win_done", done_cnt != d0, 1);
    check("win_reqs_left", exp_addr.size(), 0);
    check("win_pix_left", exp_pix.size(), 0);
    exp_addr.delete();
    exp_pix.delete();
    @(posedge clk); #2;
    check("done_once", done_cnt, d0 + 1);
  endtask

  initial begin
    int unsigned cyc, d0, sc0;
    logic [ADDR_W-1:0] want[$];

    // reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_req_valid", out_req_valid, 0);
    check("rst_req_addr", out_req_addr, 0);
    check("rst_pix_valid", out_pix_valid, 0);
    check("rst_pix", out_pix, 0);
    check("rst_pix_last", out_pix_last, 0);
    check("rst_busy", out_busy, 0);
    check("rst_done", out_done, 0);
    rst_n = 1'b1;

    // 3x3 window, one fetch per row
    run_window(0, 0, 63, 'h100, 3, 3, 0, cyc);
    want = '{20'h100, 20'h102, 20'h104};
    check("t2_nreq", req_log.size(), 3);
    for (int i = 0; i < 3; i++) if (i < req_log.size()) check("t2_addr", req_log[i], want[i]);

    // line crossing
    run_window(0, 30, 63, 0, 1, 4, 0, cyc);
    want = '{20'h000, 20'h001};
    check("t3_nreq", req_log.size(), 2);
    for (int i = 0; i < 2; i++) if (i < req_log.size()) check("t3_addr", req_log[i], want[i]);

    // backpressure on request and pixel channels
    sc0 = stall_cnt;
    req_hold = 8;
    pix_hold = 16;
    run_window(1, 5, 63, 7, 2, 3, 0, cyc);
    check("t4_req_stalled", (stall_cnt - sc0) >= 4, 1);

    // empty windows and start while busy
    run_window(3, 3, 63, 0, 0, 3, 0, cyc);
    check("t5_lat_h0", cyc <= 3, 1);
    check("t5_nreq_h0", req_log.size(), 0);
    run_window(3, 3, 63, 0, 5, 0, 0, cyc);
    check("t5_lat_w0", cyc <= 3, 1);
    check("t5_nreq_w0", req_log.size(), 0);
    run_window(2, 40, 63, 'h20, 3, 3, 1, cyc);

    // coordinate / address wrap-around
    run_window(4095, 5, 4095, 'hFFFFF, 2, 1, 0, cyc);
    want = '{20'h7FF7F, 20'hFFFFF};
    check("t6_nreq", req_log.size(), 2);
    for (int i = 0; i < 2; i++) if (i < req_log.size()) check("t6_addr", req_log[i], want[i]);

    // reset while a request is pending, then a cold refetch
    build_model(0, 0, 63, 'h40, 2, 2);
    req_hold = 60;
    @(posedge clk); #2;
    in_base_row = '0; in_base_col = '0; in_width = 12'd63; in_offset = 20'h40;
    in_win_h = 4'd2; in_win_w = 4'd2; in_start = 1'b1;
    @(posedge clk); #2;
    in_start = 1'b0;
    cyc = 0;
    while (!out_req_valid && cyc < 20) begin @(posedge clk); #2; cyc++; end
    check("t1_req_seen", out_req_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t1_req_valid", out_req_valid, 0);
    check("t1_pix_valid", out_pix_valid, 0);
    check("t1_busy", out_busy, 0);
    check("t1_done", out_done, 0);
    exp_addr.delete();
    exp_pix.delete();
    req_hold = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    check("t1_idle_quiet", done_cnt, d0);
    run_window(0, 0, 63, 'h40, 1, 2, 0, cyc);
    check("t1_cold_nreq", req_log.size(), 1);
    if (req_log.size() > 0) check("t1_cold_addr", req_log[0], 20'h40);

    // randomized windows
    rnd_rdy = 1'b1;
    mem_rnd = 1'b1;
    spur_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int unsigned br, bc, w, off, h, ww;
      br  = ($urandom_range(0, 3) == 0) ? $urandom_range(4080, 4095) : $urandom_range(0, 300);
      bc  = ($urandom_range(0, 3) == 0) ? $urandom_range(4080, 4095) : $urandom_range(0, 300);
      w   = ($urandom_range(0, 4) == 0) ? 4095 : $urandom_range(0, 200);
      off = $urandom_range(0, (1 << 20) - 1);
      h   = $urandom_range(0, 4);
      ww  = $urandom_range(0, 4);
      run_window(br, bc, w, off, h, ww, (h * ww >= 4) && ($urandom_range(0, 2) == 0), cyc);
    end
    rnd_rdy = 1'b0;
    spur_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
